// File: rtl/cpu_ctrl.sv
// cpu_ctrl: instruction register, decoder and Moore FSM sequencing the lab CPU datapath
module cpu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic        write,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);
  typedef enum logic [2:0] {WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_C} state_t;
  state_t state, next;
  logic [15:0] ir;
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op;
  logic mov_imm, mov_reg, alu, cmp, mvn, two_src;
  assign opcode = ir[15:13];
  assign op = ir[12:11];
  assign rn = ir[10:8];
  assign rd = ir[7:5];
  assign rm = ir[2:0];
  assign mov_imm = opcode == 3'b110 && op == 2'b10;
  assign mov_reg = opcode == 3'b110 && op == 2'b00;
  assign alu = opcode == 3'b101;
  assign cmp = alu && op == 2'b01;
  assign mvn = alu && op == 2'b11;
  assign two_src = alu && op != 2'b11;
  assign shift = ir[4:3];
  assign ALUop = alu ? op : 2'b00;
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  // IR only captures a new word while idle so it stays stable for a whole instruction
  always_ff @(posedge clk or posedge reset)
    if (reset) ir <= 16'h0000;
    else if (load && state == WAIT) ir <= in;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= WAIT;
    else state <= next;
  // next-state and Moore outputs per state
  always_comb begin
    next = state;
    w = 1'b0;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel = 1'b0;
    bsel = 1'b0;
    vsel = 2'b00;
    write = 1'b0;
    writenum = 3'd0;
    readnum = 3'd0;
    case (state)
      WAIT: begin
        w = 1'b1;
        next = s ? DECODE : WAIT;
      end
      DECODE: next = mov_imm ? WRITE_IMM : (mov_reg || mvn) ? GET_B : two_src ? GET_A : WAIT;
      WRITE_IMM: begin
        vsel = 2'b10;
        writenum = rn;
        write = 1'b1;
        next = WAIT;
      end
      GET_A: begin
        readnum = rn;
        loada = 1'b1;
        next = GET_B;
      end
      GET_B: begin
        readnum = rm;
        loadb = 1'b1;
        next = EXEC;
      end
      EXEC: begin
        asel = mov_reg || mvn;
        loads = cmp;
        loadc = !cmp;
        next = cmp ? WAIT : WRITE_C;
      end
      WRITE_C: begin
        writenum = rd;
        write = 1'b1;
        next = WAIT;
      end
      default: next = WAIT;
    endcase
  end
endmodule
